// File: rtl/ex_mul_div_unit.sv
// ex_mul_div_unit: iterative RV64M multiply/divide unit for the EX stage.
// Option `MDU_SINGLE_CYCLE_MUL_EN: multiplies use a one-cycle '*' product.
module ex_mul_div_unit #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            mdu_valid_i,
   input  logic [2:0]      mdu_op_i,
   input  logic            mdu_word_i,
   input  logic [XLEN-1:0] mdu_src1_i,
   input  logic [XLEN-1:0] mdu_src2_i,
   input  logic            flush_i,
   input  logic            ex_hold_i,
   output logic            mdu_stall_o,
   output logic [XLEN-1:0] mdu_result_o,
   output logic            mdu_result_valid_o,
   output logic            mdu_busy_o
);
   localparam int CW = $clog2(XLEN);
   localparam int WS = XLEN - 32;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t          r_state;
   state_t          w_state_nx;
   logic [CW-1:0]   r_cnt;
   logic [2:0]      r_op;
   logic            r_word;
   logic            r_negp;
   logic            r_negr;
   logic [XLEN-1:0] r_a;
   logic [XLEN-1:0] r_hi;
   logic [XLEN-1:0] r_lo;
   logic [XLEN-1:0] r_result;

   logic            w_accept;
   logic [2:0]      w_op;
   logic            w_sgn1;
   logic            w_sgn2;
   logic            w_neg1;
   logic            w_neg2;
   logic            w_isdiv;
   logic            w_div0;
   logic            w_ovf;
   logic            w_special;
   logic            w_fast;
   logic            w_last;
   logic            w_ge;
   logic [XLEN-1:0] w_x1;
   logic [XLEN-1:0] w_x2;
   logic [XLEN-1:0] w_mag1;
   logic [XLEN-1:0] w_mag2;
   logic [XLEN-1:0] w_dvd;
   logic [XLEN-1:0] w_min;
   logic [XLEN-1:0] w_special_res;
   logic [XLEN-1:0] w_fast_res;
   logic [XLEN:0]   w_madd;
   logic [XLEN:0]   w_rem;
   logic [XLEN:0]   w_rsub;
   logic [XLEN-1:0] w_hi_nx;
   logic [XLEN-1:0] w_lo_nx;
   logic [2*XLEN-1:0] w_pmag;
   logic [XLEN-1:0] w_iter_res;

   function automatic logic [XLEN-1:0] f_sext32(input logic [XLEN-1:0] v);
      return {{WS{v[31]}}, v[31:0]};
   endfunction

   function automatic logic [XLEN-1:0] f_mul(
      input logic [2*XLEN-1:0] pmag,
      input logic              neg,
      input logic              hi,
      input logic              word
   );
      logic [2*XLEN-1:0] p;
      logic [XLEN-1:0]   v;
      p = neg ? -pmag : pmag;
      v = hi ? p[2*XLEN-1:XLEN] : p[XLEN-1:0];
      return word ? f_sext32(v) : v;
   endfunction

   function automatic logic [XLEN-1:0] f_div(
      input logic [XLEN-1:0] q,
      input logic [XLEN-1:0] r,
      input logic            negq,
      input logic            negr,
      input logic            rem,
      input logic            word
   );
      logic [XLEN-1:0] v;
      v = rem ? (negr ? -r : r) : (negq ? -q : q);
      return word ? f_sext32(v) : v;
   endfunction

   // Illegal W forms of MULH/MULHSU/MULHU collapse to MULW.
   assign w_op = (mdu_word_i && !mdu_op_i[2]) ? 3'd0 : mdu_op_i;

   always_comb begin
      w_sgn1 = 1'b0;
      w_sgn2 = 1'b0;
      unique case (w_op)
         3'd0, 3'd1, 3'd4, 3'd6: begin
            w_sgn1 = 1'b1;
            w_sgn2 = 1'b1;
         end
         3'd2:    w_sgn1 = 1'b1;
         default: ;
      endcase
   end

   assign w_x1 = !mdu_word_i ? mdu_src1_i :
                 w_sgn1 ? f_sext32(mdu_src1_i) :
                 {{WS{1'b0}}, mdu_src1_i[31:0]};
   assign w_x2 = !mdu_word_i ? mdu_src2_i :
                 w_sgn2 ? f_sext32(mdu_src2_i) :
                 {{WS{1'b0}}, mdu_src2_i[31:0]};

   assign w_neg1 = w_sgn1 & w_x1[XLEN-1];
   assign w_neg2 = w_sgn2 & w_x2[XLEN-1];
   assign w_mag1 = w_neg1 ? -w_x1 : w_x1;
   assign w_mag2 = w_neg2 ? -w_x2 : w_x2;

   assign w_dvd = mdu_word_i ? f_sext32(mdu_src1_i) : mdu_src1_i;
   assign w_min = mdu_word_i ? {{(XLEN-31){1'b1}}, {31{1'b0}}}
                             : {1'b1, {(XLEN-1){1'b0}}};

   assign w_isdiv   = w_op[2];
   assign w_div0    = w_isdiv & (w_x2 == '0);
   assign w_ovf     = w_isdiv & !w_op[0] & (w_x1 == w_min) & (&w_x2);
   assign w_special = w_div0 | w_ovf;

   always_comb begin
      w_special_res = '0;
      if (w_op[1]) w_special_res = w_div0 ? w_dvd : '0;
      else         w_special_res = w_div0 ? '1 : w_dvd;
   end

`ifdef MDU_SINGLE_CYCLE_MUL_EN
   logic [2*XLEN-1:0] w_fprod;
   assign w_fprod    = {{XLEN{1'b0}}, w_mag1} * {{XLEN{1'b0}}, w_mag2};
   assign w_fast     = !w_isdiv;
   assign w_fast_res = f_mul(w_fprod, w_neg1 ^ w_neg2,
                             w_op != 3'd0, mdu_word_i);
`else
   assign w_fast     = 1'b0;
   assign w_fast_res = '0;
`endif

   assign w_accept = (r_state == S_IDLE) & mdu_valid_i & !flush_i;
   assign w_last   = r_cnt == (r_word ? CW'(31) : CW'(XLEN-1));

   // Mul: shift-add into {hi,lo}. Div: restoring, quotient shifts into lo.
   assign w_madd  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
   assign w_rem   = {r_hi, r_lo[XLEN-1]};
   assign w_rsub  = w_rem - {1'b0, r_a};
   assign w_ge    = w_rem >= {1'b0, r_a};
   assign w_hi_nx = r_op[2] ? (w_ge ? w_rsub[XLEN-1:0] : w_rem[XLEN-1:0])
                            : w_madd[XLEN:1];
   assign w_lo_nx = r_op[2] ? {r_lo[XLEN-2:0], w_ge}
                            : {w_madd[0], r_lo[XLEN-1:1]};

   // A 32-step multiply leaves the product shifted up by WS bits.
   assign w_pmag = r_word ? ({w_hi_nx, w_lo_nx} >> WS) : {w_hi_nx, w_lo_nx};
   assign w_iter_res = r_op[2]
      ? f_div(w_lo_nx, w_hi_nx, r_negp, r_negr, r_op[1], r_word)
      : f_mul(w_pmag, r_negp, r_op != 3'd0, r_word);

   always_comb begin
      w_state_nx = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_accept)
               w_state_nx = (w_special | w_fast) ? S_DONE : S_BUSY;
         end
         S_BUSY: begin
            if (flush_i)     w_state_nx = S_IDLE;
            else if (w_last) w_state_nx = S_DONE;
         end
         S_DONE: begin
            if (flush_i || !ex_hold_i) w_state_nx = S_IDLE;
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_op     <= '0;
         r_word   <= 1'b0;
         r_negp   <= 1'b0;
         r_negr   <= 1'b0;
         r_a      <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_result <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_cnt  <= '0;
                  r_op   <= w_op;
                  r_word <= mdu_word_i;
                  r_negp <= w_neg1 ^ w_neg2;
                  r_negr <= w_neg1;
                  r_a    <= w_mag2;
                  r_hi   <= '0;
                  r_lo   <= (w_isdiv & mdu_word_i) ? (w_mag1 << WS) : w_mag1;
                  if (w_special)   r_result <= w_special_res;
                  else if (w_fast) r_result <= w_fast_res;
               end
            end
            S_BUSY: begin
               if (!flush_i) begin
                  r_hi  <= w_hi_nx;
                  r_lo  <= w_lo_nx;
                  r_cnt <= r_cnt + CW'(1);
                  if (w_last) r_result <= w_iter_res;
               end
            end
            default: ;
         endcase
      end
   end

   assign mdu_stall_o = rst_n & mdu_valid_i & !flush_i & (r_state != S_DONE);
   assign mdu_result_o       = r_result;
   assign mdu_result_valid_o = r_state == S_DONE;
   assign mdu_busy_o         = r_state != S_IDLE;

endmodule

// File: tb/tb_ex_mul_div_unit.sv
// tb_ex_mul_div_unit: directed checks of ex_mul_div_unit.
// Build with +define+MDU_SINGLE_CYCLE_MUL_EN to check the fast-multiply variant.
module tb_ex_mul_div_unit;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        mdu_valid_i;
   logic [2:0]  mdu_op_i;
   logic        mdu_word_i;
   logic [63:0] mdu_src1_i;
   logic [63:0] mdu_src2_i;
   logic        flush_i;
   logic        ex_hold_i;
   logic        mdu_stall_o;
   logic [63:0] mdu_result_o;
   logic        mdu_result_valid_o;
   logic        mdu_busy_o;

   int total = 0;
   int bad = 0;

`ifdef MDU_SINGLE_CYCLE_MUL_EN
   localparam int LM64 = 1;
   localparam int LM32 = 1;
`else
   localparam int LM64 = 65;
   localparam int LM32 = 33;
`endif
   localparam int LD64 = 65;
   localparam int LD32 = 33;

   ex_mul_div_unit #(.XLEN(64)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .mdu_valid_i        (mdu_valid_i),
      .mdu_op_i           (mdu_op_i),
      .mdu_word_i         (mdu_word_i),
      .mdu_src1_i         (mdu_src1_i),
      .mdu_src2_i         (mdu_src2_i),
      .flush_i            (flush_i),
      .ex_hold_i          (ex_hold_i),
      .mdu_stall_o        (mdu_stall_o),
      .mdu_result_o       (mdu_result_o),
      .mdu_result_valid_o (mdu_result_valid_o),
      .mdu_busy_o         (mdu_busy_o)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic [2:0] op, input logic wd,
                        input logic [63:0] a, input logic [63:0] b);
      @(posedge clk);
      #1;
      mdu_valid_i = 1'b1;
      mdu_op_i    = op;
      mdu_word_i  = wd;
      mdu_src1_i  = a;
      mdu_src2_i  = b;
   endtask

   task automatic run_op(input string nm, input logic [2:0] op,
                         input logic wd, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp,
                         input int exp_lat);
      int lat;
      int nst;
      lat = -1;
      nst = 0;
      drive(op, wd, a, b);
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (mdu_result_valid_o) begin
            lat = c;
            break;
         end
         if (mdu_stall_o) nst++;
      end
      total++;
      if (lat !== exp_lat) begin
         bad++;
         $display("FAIL %s latency: got %0d want %0d", nm, lat, exp_lat);
      end
      total++;
      if (nst !== exp_lat) begin
         bad++;
         $display("FAIL %s stall cycles: got %0d want %0d", nm, nst, exp_lat);
      end
      total++;
      if (mdu_result_o !== exp) begin
         bad++;
         $display("FAIL %s result: got %h want %h", nm, mdu_result_o, exp);
      end
      total++;
      if (mdu_stall_o !== 1'b0) begin
         bad++;
         $display("FAIL %s done stall: got %b want 0", nm, mdu_stall_o);
      end
      @(posedge clk);
      #1;
      mdu_valid_i = 1'b0;
   endtask

   task automatic test_reset;
      rst_n       = 1'b0;
      mdu_valid_i = 1'b0;
      mdu_op_i    = '0;
      mdu_word_i  = 1'b0;
      mdu_src1_i  = '0;
      mdu_src2_i  = '0;
      flush_i     = 1'b0;
      ex_hold_i   = 1'b0;
      #12;
      total++;
      if ({mdu_stall_o, mdu_result_valid_o, mdu_busy_o} !== 3'b000) begin
         bad++;
         $display("FAIL reset flags: got %b want 000",
                  {mdu_stall_o, mdu_result_valid_o, mdu_busy_o});
      end
      total++;
      if (mdu_result_o !== 64'd0) begin
         bad++;
         $display("FAIL reset result: got %h want 0", mdu_result_o);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_mul;
      run_op("mul_7_m3", 3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD,
             64'hFFFF_FFFF_FFFF_FFEB, LM64);
      run_op("mulhu_ones", 3'd3, 1'b0, '1, '1,
             64'hFFFF_FFFF_FFFF_FFFE, LM64);
      run_op("mulh_min_2", 3'd1, 1'b0, 64'h8000_0000_0000_0000, 64'd2,
             64'hFFFF_FFFF_FFFF_FFFF, LM64);
      run_op("mulhsu_m1_2", 3'd2, 1'b0, '1, 64'd2,
             64'hFFFF_FFFF_FFFF_FFFF, LM64);
      run_op("mulw", 3'd0, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2,
             64'hFFFF_FFFF_FFFF_FFFE, LM32);
      run_op("illegal_mulhw", 3'd1, 1'b1, 64'd3, 64'd5, 64'd15, LM32);
   endtask

   task automatic test_div_special;
      run_op("divu_by0", 3'd5, 1'b0, 64'd100, 64'd0, '1, 1);
      run_op("remu_by0", 3'd7, 1'b0, 64'd100, 64'd0, 64'd100, 1);
      run_op("div_ovf", 3'd4, 1'b0, 64'h8000_0000_0000_0000, '1,
             64'h8000_0000_0000_0000, 1);
      run_op("rem_ovf", 3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1);
      run_op("remw_by0", 3'd6, 1'b1, 64'h1234_5678_9ABC_DEF0,
             64'h0000_0001_0000_0000, 64'hFFFF_FFFF_9ABC_DEF0, 1);
      run_op("divw_ovf", 3'd4, 1'b1, 64'h0000_0000_8000_0000,
             64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
   endtask

   task automatic test_div_iter;
      run_op("divw", 3'd4, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2,
             64'hFFFF_FFFF_FFFF_FFFD, LD32);
      run_op("remw", 3'd6, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, '1, LD32);
      run_op("div_m7_2", 3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
             64'hFFFF_FFFF_FFFF_FFFD, LD64);
      run_op("rem_m7_2", 3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
             '1, LD64);
      run_op("remu_100_7", 3'd7, 1'b0, 64'd100, 64'd7, 64'd2, LD64);
      run_op("divuw", 3'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
             64'h0000_0000_7FFF_FFFC, LD32);
      run_op("remuw", 3'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
             64'd1, LD32);
   endtask

   task automatic test_flush;
      int seen;
      logic [2:0] fop;
`ifdef MDU_SINGLE_CYCLE_MUL_EN
      fop = 3'd5;
`else
      fop = 3'd3;
`endif
      seen = 0;
      drive(fop, 1'b0, '1, 64'd3);
      repeat (9) @(posedge clk);
      @(negedge clk);
      total++;
      if (mdu_busy_o !== 1'b1) begin
         bad++;
         $display("FAIL flush pre busy: got %b want 1", mdu_busy_o);
      end
      @(posedge clk);
      #1;
      flush_i = 1'b1;
      @(negedge clk);
      total++;
      if (mdu_stall_o !== 1'b0) begin
         bad++;
         $display("FAIL flush stall: got %b want 0", mdu_stall_o);
      end
      @(posedge clk);
      #1;
      flush_i     = 1'b0;
      mdu_valid_i = 1'b0;
      total++;
      if ({mdu_busy_o, mdu_result_valid_o} !== 2'b00) begin
         bad++;
         $display("FAIL flush idle: got %b want 00",
                  {mdu_busy_o, mdu_result_valid_o});
      end
      for (int c = 0; c < 80; c++) begin
         @(negedge clk);
         if (mdu_result_valid_o) seen++;
      end
      total++;
      if (seen !== 0) begin
         bad++;
         $display("FAIL flush valid cycles: got %0d want 0", seen);
      end
   endtask

   task automatic test_hold;
      int lat;
      lat = -1;
      ex_hold_i = 1'b1;
      drive(3'd7, 1'b0, 64'd100, 64'd7);
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (mdu_result_valid_o) begin
            lat = c;
            break;
         end
      end
      total++;
      if (lat !== LD64) begin
         bad++;
         $display("FAIL hold latency: got %0d want %0d", lat, LD64);
      end
      for (int k = 0; k < 3; k++) begin
         if (k != 0) @(negedge clk);
         total++;
         if ({mdu_result_valid_o, mdu_stall_o, mdu_busy_o} !== 3'b101 ||
             mdu_result_o !== 64'd2) begin
            bad++;
            $display("FAIL hold cycle %0d: got v/s/b %b res %h want 101 res 2",
                     k, {mdu_result_valid_o, mdu_stall_o, mdu_busy_o},
                     mdu_result_o);
         end
      end
      @(posedge clk);
      #1;
      ex_hold_i = 1'b0;
      @(posedge clk);
      #1;
      mdu_valid_i = 1'b0;
      @(negedge clk);
      total++;
      if ({mdu_result_valid_o, mdu_busy_o} !== 2'b00) begin
         bad++;
         $display("FAIL hold release: got %b want 00",
                  {mdu_result_valid_o, mdu_busy_o});
      end
   endtask

   task automatic test_reset_mid;
      int seen;
      seen = 0;
      drive(3'd5, 1'b0, 64'd1000, 64'd3);
      repeat (5) @(posedge clk);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if ({mdu_stall_o, mdu_result_valid_o, mdu_busy_o} !== 3'b000 ||
          mdu_result_o !== 64'd0) begin
         bad++;
         $display("FAIL async reset: got s/v/b %b res %h want 000 res 0",
                  {mdu_stall_o, mdu_result_valid_o, mdu_busy_o},
                  mdu_result_o);
      end
      mdu_valid_i = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int c = 0; c < 80; c++) begin
         @(negedge clk);
         if (mdu_result_valid_o || mdu_busy_o) seen++;
      end
      total++;
      if (seen !== 0) begin
         bad++;
         $display("FAIL reset drop: got %0d active cycles want 0", seen);
      end
   endtask

   task automatic test_back_to_back;
      run_op("b2b_divu", 3'd5, 1'b0, 64'd1000, 64'd3, 64'd333, LD64);
      run_op("b2b_mul", 3'd0, 1'b0, 64'd6, 64'd7, 64'd42, LM64);
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div_special();
      test_div_iter();
      test_flush();
      test_hold();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
